// File: rtl/day11_serial_comparator.sv
// Bit-serial unsigned magnitude comparator: walks two WIDTH-bit words LSB first,
// letting each more significant differing bit override the running relation.
module day11_serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             s
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ,
        REL_GT,
        REL_LT
    } rel_t;

    state_t           state_q, state_d;
    rel_t             rel_q,   rel_d;
    logic [WIDTH-1:0] sa_q,    sa_d;
    logic [WIDTH-1:0] sb_q,    sb_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             g_q,     g_d;
    logic             e_q,     e_d;
    logic             s_q,     s_d;

    rel_t             rel_step;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        rel_step = rel_q;
        if (sa_q[0] && !sb_q[0]) begin
            rel_step = REL_GT;
        end else if (!sa_q[0] && sb_q[0]) begin
            rel_step = REL_LT;
        end
    end

    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        g_d     = g_q;
        e_d     = e_q;
        s_d     = s_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a_word;
                    sb_d    = b_word;
                    cnt_d   = '0;
                    rel_d   = REL_EQ;
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    s_d     = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rel_d = rel_step;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                if (last_bit) begin
                    // Counter holds at WIDTH-1 so it never wraps.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    g_d     = (rel_step == REL_GT);
                    e_d     = (rel_step == REL_EQ);
                    s_d     = (rel_step == REL_LT);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rel_q   <= REL_EQ;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            g_q     <= g_d;
            e_q     <= e_d;
            s_q     <= s_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = g_q;
    assign e    = e_q;
    assign s    = s_q;

endmodule

// File: tb/tb_day11_serial_comparator.sv
// Scoreboard bench for day11_serial_comparator: stimulus pushes expected results,
// a monitor pops and checks them whenever done pulses.
module tb_day11_serial_comparator;

    localparam int WIDTH = 8;

    typedef struct {
        logic g;
        logic e;
        logic s;
        int   due;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             s;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;

    day11_serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_word (a_word),
        .b_word (b_word),
        .busy   (busy),
        .done   (done),
        .g      (g),
        .e      (e),
        .s      (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, required no done", cycle_cnt);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    if ({g, e, s} !== {x.g, x.e, x.s}) begin
                        errors++;
                        $display("[TB] FAIL result_ges: got %b%b%b, required %b%b%b", g, e, s, x.g, x.e, x.s);
                    end
                    checks++;
                    if (cycle_cnt != x.due) begin
                        errors++;
                        $display("[TB] FAIL done_timing: got cycle %0d, required cycle %0d", cycle_cnt, x.due);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic eb, input logic ed,
                               input logic eg, input logic ee, input logic es);
        checks++;
        if ({busy, done, g, e, s} !== {eb, ed, eg, ee, es}) begin
            errors++;
            $display("[TB] FAIL %s: got busy/done/g/e/s=%b%b%b%b%b, required %b%b%b%b%b",
                     name, busy, done, g, e, s, eb, ed, eg, ee, es);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending results, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // One compare from idle; operands are scrambled right after acceptance.
    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic eg, input logic ee, input logic es);
        exp_t x;
        @(negedge clk);
        a_word = a;
        b_word = b;
        start  = 1'b1;
        x.g = eg; x.e = ee; x.s = es;
        x.due = cycle_cnt + 1 + WIDTH;
        sb_q.push_back(x);
        @(negedge clk);
        start  = 1'b0;
        a_word = ~a;
        b_word = b ^ 8'h81;
        waitDrain(name);
        @(negedge clk);
        @(negedge clk);
        checkOutput({name, "_held"}, 1'b0, 1'b0, eg, ee, es);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_word = '0;
        b_word = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 4) checkOutput("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        applyStimulus("a5_vs_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        applyStimulus("3c_vs_3c", 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
        applyStimulus("00_vs_ff", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus("80_vs_7f", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
        applyStimulus("01_vs_00", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus("02_vs_03", 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);

        // Start held high for 30 cycles; only offsets 0, 10 and 20 are accepted.
        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] av;
            logic [WIDTH-1:0] bv;
            @(negedge clk);
            checks++;
            if (busy !== ((i % 10) != 0)) begin
                errors++;
                $display("[TB] FAIL held_busy_%0d: got %b, required %b", i, busy, ((i % 10) != 0));
            end
            av = 8'(i * 53 + 200);
            bv = 8'(i * 29 + 100);
            if (i == 10) bv = av;
            a_word = av;
            b_word = bv;
            start  = 1'b1;
            if (i % 10 == 0) begin
                exp_t x;
                x.g = (av > bv); x.e = (av == bv); x.s = (av < bv);
                x.due = cycle_cnt + 1 + WIDTH;
                sb_q.push_back(x);
            end
        end
        @(negedge clk);
        start = 1'b0;
        waitDrain("held_start");

        // Reset four edges into a compare aborts it without a done.
        @(negedge clk);
        a_word = 8'h10;
        b_word = 8'h20;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        checkOutput("abort_no_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("c3_vs_c4", 8'hC3, 8'hC4, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/day11_serial_comparator.md
# day11_serial_comparator

Bit-serial magnitude comparator that evaluates two unsigned WIDTH-bit words one bit per clock, LSB first, by cascading the single-bit greater/equal/smaller relation. It is the multi-bit, sequential counterpart of the team's 1-bit comparator. It sits behind any block that needs a registered compare result and can tolerate WIDTH+1 cycles of latency in exchange for one bit-slice of logic.

## Interface
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- a_word  input  WIDTH  operand A, unsigned; captured on the accepting edge.
- b_word  input  WIDTH  operand B, unsigned; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; the result is valid.
- g  output  1  A > B.
- e  output  1  A == B.
- s  output  1  A < B.

## Operation
- State machine with states IDLE, RUN and DONE. All outputs are registered.
- IDLE, start=1:
  - Load a_word into shift register sa and b_word into sb.
  - Set cnt = 0 and the relation register rel = EQ.
  - Clear g, e and s to 0.
  - Go to RUN.
- IDLE, start=0: hold all state.
- RUN: each edge examines a = sa[0] and b = sb[0]:
  - a & ~b: rel = GT.
  - ~a & b: rel = LT.
  - a ~^ b: rel unchanged.
  - Then shift sa and sb right by one and increment cnt.
- Because bits arrive LSB first, a later (more significant) differing bit overrides any earlier relation. The final rel is therefore the true magnitude relation.
- When RUN processes the bit with cnt == WIDTH-1:
  - Go to DONE.
  - On the same edge, load g/e/s from the final rel: GT gives 100, EQ gives 010, LT gives 001.
- DONE: done=1 for exactly this cycle. The next edge goes to IDLE unconditionally.
- g/e/s are one-hot from DONE onward. They hold until the next accepted start clears them.
- start in RUN or DONE is ignored, not queued.
- start held continuously high: a new compare is accepted on every IDLE cycle, one every WIDTH+2 cycles.
- Operands are captured once. Changes to a_word/b_word after the accepting edge have no effect.
- cnt is $clog2(WIDTH) bits wide. It never wraps, because RUN exits at WIDTH-1.

## Timing
- Reset (asynchronous assert, any state):
  - State = IDLE.
  - busy=0, done=0, g=0, e=0, s=0.
  - sa, sb, cnt and rel are cleared.
- Reset in the middle of an operation aborts the compare. No done is issued.
- Deassertion of rst_n is synchronised externally. The block is idle on the first edge after release.
- Start accepted at edge k:
  - busy=1 from edge k.
  - RUN occupies edges k+1 through k+WIDTH.
  - done=1 and g/e/s valid from edge k+WIDTH until edge k+WIDTH+1.
  - busy=0 and done=0 after edge k+WIDTH+1.
- Latency from the accepting edge to the first result-valid cycle is WIDTH edges.
- Throughput is one compare per WIDTH+2 cycles.

## Test plan
- Reset, then idle: while rst_n=0, require busy/done/g/e/s all 0. After release with start=0 for 20 cycles, require no change.
- WIDTH=8, a=8'hA5, b=8'h5A, start pulse: require done exactly 8 edges after acceptance for one cycle, g=1 e=0 s=0, and g held after done falls.
- a=8'h3C, b=8'h3C gives e=1. a=8'h00, b=8'hFF gives s=1. a=8'h80, b=8'h7F gives g=1, checking that the MSB overrides an LSB-first LT.
- a=8'h01, b=8'h00 gives g=1. a=8'h02, b=8'h03 gives s=1, checking that a later equal MSB does not clear an earlier relation.
- start held high for 30 cycles with changing operands: require acceptance every 10 cycles, mid-run operand changes ignored, and one done per compare.
- rst_n pulsed low 4 edges after acceptance: require immediate IDLE with outputs at reset values, no done, and a correct result for the next compare.
